// File: rtl/arp_table_reg_master_pkg.sv
// Shared constants for the ARP table register master: word offsets, command codes, status bits.
package arp_table_reg_master_pkg;

    localparam int unsigned ARP_REG_W    = 32;
    localparam int unsigned ARP_MAC_W    = 48;
    localparam int unsigned ARP_TO_CNT_W = 8;

    localparam logic [2:0] ARP_REG_IP     = 3'd0;
    localparam logic [2:0] ARP_REG_MAC_HI = 3'd1;
    localparam logic [2:0] ARP_REG_MAC_LO = 3'd2;
    localparam logic [2:0] ARP_REG_INDEX  = 3'd3;
    localparam logic [2:0] ARP_REG_CMD    = 3'd4;
    localparam logic [2:0] ARP_REG_STATUS = 3'd5;

    localparam logic [31:0] ARP_CMD_RD = 32'd1;
    localparam logic [31:0] ARP_CMD_WR = 32'd2;

    localparam int unsigned ARP_STAT_BUSY     = 0;
    localparam int unsigned ARP_STAT_TIMEOUT  = 1;
    localparam int unsigned ARP_STAT_CMD_DROP = 2;
    localparam int unsigned ARP_STAT_DONE     = 3;

endpackage

// File: rtl/arp_table_reg_master.sv
// Register-bus master staging IP/MAC/index words and issuing one ARP table
// read or write at a time, with ack/timeout handling and sticky status.
module arp_table_reg_master
    import arp_table_reg_master_pkg::*;
#(
    parameter int unsigned LUT_DEPTH      = 32,
    parameter int unsigned LUT_DEPTH_BITS = $clog2(LUT_DEPTH),
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      reg_req,
    input  logic                      reg_rd_wr_L,
    input  logic [2:0]                reg_addr,
    input  logic [ARP_REG_W-1:0]      reg_wr_data,
    output logic                      reg_ack,
    output logic [ARP_REG_W-1:0]      reg_rd_data,
    output logic [LUT_DEPTH_BITS-1:0] arp_rd_addr,
    output logic                      arp_rd_req,
    input  logic [ARP_MAC_W-1:0]      arp_rd_mac,
    input  logic [ARP_REG_W-1:0]      arp_rd_ip,
    input  logic                      arp_rd_ack,
    output logic [LUT_DEPTH_BITS-1:0] arp_wr_addr,
    output logic                      arp_wr_req,
    output logic [ARP_MAC_W-1:0]      arp_wr_mac,
    output logic [ARP_REG_W-1:0]      arp_wr_ip,
    input  logic                      arp_wr_ack
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_WR_WAIT = 2'd2;

    logic [1:0]                state_q;
    logic [1:0]                state_next;
    logic [ARP_TO_CNT_W-1:0]   cnt_q;
    logic [ARP_REG_W-1:0]      ip_q;
    logic [ARP_MAC_W-1:0]      mac_q;
    logic [LUT_DEPTH_BITS-1:0] index_q;
    logic                      timeout_q;
    logic                      cmd_drop_q;
    logic                      done_q;
    logic                      rd_req_q;
    logic                      wr_req_q;
    logic                      reg_ack_q;
    logic [ARP_REG_W-1:0]      reg_rd_data_q;

    logic                      wr_en_c;
    logic                      rd_en_c;
    logic                      busy_c;
    logic                      cnt_last_c;
    logic                      cmd_wr_c;
    logic                      stat_wr_c;
    logic                      rd_done_c;
    logic                      wr_done_c;
    logic                      to_hit_c;
    logic                      drop_set_c;
    logic [ARP_REG_W-1:0]      rd_mux_c;

    assign wr_en_c    = reg_req && !reg_rd_wr_L;
    assign rd_en_c    = reg_req && reg_rd_wr_L;
    assign busy_c     = (state_q != ST_IDLE);
    assign cnt_last_c = ((cnt_q + ARP_TO_CNT_W'(1)) == ARP_TO_CNT_W'(TIMEOUT));
    assign cmd_wr_c   = wr_en_c && (reg_addr == ARP_REG_CMD);
    assign stat_wr_c  = wr_en_c && (reg_addr == ARP_REG_STATUS);
    assign drop_set_c = cmd_wr_c && busy_c;

    // Next-state logic; an ack in the same cycle as the last count wins over timeout.
    always_comb begin
        state_next = state_q;
        rd_done_c  = 1'b0;
        wr_done_c  = 1'b0;
        to_hit_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_wr_c && (reg_wr_data == ARP_CMD_RD)) begin
                    state_next = ST_RD_WAIT;
                end else if (cmd_wr_c && (reg_wr_data == ARP_CMD_WR)) begin
                    state_next = ST_WR_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (arp_rd_ack) begin
                    rd_done_c  = 1'b1;
                    state_next = ST_IDLE;
                end else if (cnt_last_c) begin
                    to_hit_c   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_WR_WAIT: begin
                if (arp_wr_ack) begin
                    wr_done_c  = 1'b1;
                    state_next = ST_IDLE;
                end else if (cnt_last_c) begin
                    to_hit_c   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
        end else begin
            state_q  <= state_next;
            rd_req_q <= (state_next == ST_RD_WAIT);
            wr_req_q <= (state_next == ST_WR_WAIT);
        end
    end

    // Counter restarts on every idle cycle, so it reads 0 on the first wait cycle.
    always_ff @(posedge clk) begin
        if (reset || !busy_c) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + ARP_TO_CNT_W'(1);
        end
    end

    // Staging registers: software writes only when idle, table read result when acked.
    always_ff @(posedge clk) begin
        if (reset) begin
            ip_q    <= '0;
            mac_q   <= '0;
            index_q <= '0;
        end else if (rd_done_c) begin
            ip_q  <= arp_rd_ip;
            mac_q <= arp_rd_mac;
        end else if (wr_en_c && !busy_c) begin
            case (reg_addr)
                ARP_REG_IP:     ip_q           <= reg_wr_data;
                ARP_REG_MAC_HI: mac_q[47:32]   <= reg_wr_data[15:0];
                ARP_REG_MAC_LO: mac_q[31:0]    <= reg_wr_data;
                ARP_REG_INDEX:  index_q        <= reg_wr_data[LUT_DEPTH_BITS-1:0];
                default:        ;
            endcase
        end
    end

    // Sticky status bits; a set event in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_q  <= 1'b0;
            cmd_drop_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            timeout_q  <= to_hit_c ||
                          (timeout_q && !(stat_wr_c && reg_wr_data[ARP_STAT_TIMEOUT]));
            cmd_drop_q <= drop_set_c ||
                          (cmd_drop_q && !(stat_wr_c && reg_wr_data[ARP_STAT_CMD_DROP]));
            done_q     <= rd_done_c || wr_done_c ||
                          (done_q && !(stat_wr_c && reg_wr_data[ARP_STAT_DONE]));
        end
    end

    always_comb begin
        rd_mux_c = '0;
        case (reg_addr)
            ARP_REG_IP:     rd_mux_c = ip_q;
            ARP_REG_MAC_HI: rd_mux_c = {16'h0000, mac_q[47:32]};
            ARP_REG_MAC_LO: rd_mux_c = mac_q[31:0];
            ARP_REG_INDEX:  rd_mux_c = ARP_REG_W'(index_q);
            ARP_REG_STATUS: begin
                rd_mux_c[ARP_STAT_BUSY]     = busy_c;
                rd_mux_c[ARP_STAT_TIMEOUT]  = timeout_q;
                rd_mux_c[ARP_STAT_CMD_DROP] = cmd_drop_q;
                rd_mux_c[ARP_STAT_DONE]     = done_q;
            end
            default:        rd_mux_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_ack_q     <= 1'b0;
            reg_rd_data_q <= '0;
        end else begin
            reg_ack_q     <= reg_req;
            reg_rd_data_q <= rd_en_c ? rd_mux_c : '0;
        end
    end

    assign reg_ack     = reg_ack_q;
    assign reg_rd_data = reg_rd_data_q;
    assign arp_rd_req  = rd_req_q;
    assign arp_wr_req  = wr_req_q;
    assign arp_rd_addr = index_q;
    assign arp_wr_addr = index_q;
    assign arp_wr_ip   = ip_q;
    assign arp_wr_mac  = mac_q;

endmodule

// File: tb/tb_arp_table_reg_master.sv
// Directed bench for arp_table_reg_master (TIMEOUT=4) with a cycle-stepped ARP table model.
module tb_arp_table_reg_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_req;
    logic        reg_rd_wr_L;
    logic [2:0]  reg_addr;
    logic [31:0] reg_wr_data;
    logic        reg_ack;
    logic [31:0] reg_rd_data;
    logic [4:0]  arp_rd_addr;
    logic        arp_rd_req;
    logic [47:0] arp_rd_mac;
    logic [31:0] arp_rd_ip;
    logic        arp_rd_ack;
    logic [4:0]  arp_wr_addr;
    logic        arp_wr_req;
    logic [47:0] arp_wr_mac;
    logic [31:0] arp_wr_ip;
    logic        arp_wr_ack;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    arp_table_reg_master #(
        .LUT_DEPTH(32),
        .TIMEOUT  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .reg_req    (reg_req),
        .reg_rd_wr_L(reg_rd_wr_L),
        .reg_addr   (reg_addr),
        .reg_wr_data(reg_wr_data),
        .reg_ack    (reg_ack),
        .reg_rd_data(reg_rd_data),
        .arp_rd_addr(arp_rd_addr),
        .arp_rd_req (arp_rd_req),
        .arp_rd_mac (arp_rd_mac),
        .arp_rd_ip  (arp_rd_ip),
        .arp_rd_ack (arp_rd_ack),
        .arp_wr_addr(arp_wr_addr),
        .arp_wr_req (arp_wr_req),
        .arp_wr_mac (arp_wr_mac),
        .arp_wr_ip  (arp_wr_ip),
        .arp_wr_ack (arp_wr_ack)
    );

    task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        reg_req = 1'b1; reg_rd_wr_L = 1'b0; reg_addr = a; reg_wr_data = d;
        @(negedge clk);
        reg_req = 1'b0; reg_wr_data = '0;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [31:0] d, output logic k);
        @(negedge clk);
        reg_req = 1'b1; reg_rd_wr_L = 1'b1; reg_addr = a;
        @(negedge clk);
        d = reg_rd_data; k = reg_ack;
        reg_req = 1'b0; reg_rd_wr_L = 1'b0;
    endtask

    // Table model: acks on the delay-th cycle the request is seen high (0 = never).
    task automatic run_table(input int delay, input logic is_rd, output int hi_cycles);
        int   cnt;
        logic req;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            req = is_rd ? arp_rd_req : arp_wr_req;
            arp_rd_ack = 1'b0; arp_wr_ack = 1'b0;
            if (req) begin
                cnt++;
                if (cnt == delay) begin
                    if (is_rd) arp_rd_ack = 1'b1;
                    else       arp_wr_ack = 1'b1;
                end
            end else if (cnt > 0) begin
                break;
            end
            @(negedge clk);
        end
        arp_rd_ack = 1'b0; arp_wr_ack = 1'b0;
        hi_cycles = cnt;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic        k;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({reg_ack, arp_rd_req, arp_wr_req} !== 3'b000 || reg_rd_data !== 32'h0 ||
            arp_wr_ip !== 32'h0 || arp_wr_mac !== 48'h0 || arp_rd_addr !== 5'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: ack=%b rdreq=%b wrreq=%b rdata=%h ip=%h mac=%h addr=%h, want all 0",
                     reg_ack, arp_rd_req, arp_wr_req, reg_rd_data, arp_wr_ip, arp_wr_mac, arp_rd_addr);
        end
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            reg_read(3'(a), d, k);
            n_checks++;
            if (d !== 32'h0 || k !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_read word%0d: data=%h ack=%b, want 0/1", a, d, k);
            end
        end
    endtask

    task automatic test_write_path;
        logic [31:0] d;
        logic        k;
        int          hc;
        reg_write(3'd0, 32'hC0A80001);
        reg_write(3'd1, 32'h00000011);
        reg_write(3'd2, 32'h22334455);
        reg_write(3'd3, 32'd5);
        reg_write(3'd4, 32'd2);
        n_checks++;
        if (arp_wr_req !== 1'b1 || arp_rd_req !== 1'b0 || arp_wr_addr !== 5'd5 ||
            arp_wr_mac !== 48'h001122334455 || arp_wr_ip !== 32'hC0A80001) begin
            n_fail++;
            $display("FAIL wr_request: wrreq=%b rdreq=%b addr=%0d mac=%h ip=%h, want 1 0 5 001122334455 c0a80001",
                     arp_wr_req, arp_rd_req, arp_wr_addr, arp_wr_mac, arp_wr_ip);
        end
        run_table(3, 1'b0, hc);
        n_checks++;
        if (hc !== 3) begin
            n_fail++;
            $display("FAIL wr_req_cycles: got %0d, want 3", hc);
        end
        reg_read(3'd5, d, k);
        n_checks++;
        if (d !== 32'h8) begin
            n_fail++;
            $display("FAIL wr_status: got %h, want 8", d);
        end
        reg_read(3'd1, d, k);
        n_checks++;
        if (d !== 32'h0011) begin
            n_fail++;
            $display("FAIL wr_mac_hi_read: got %h, want 00000011", d);
        end
        reg_write(3'd5, 32'h8);
        reg_read(3'd5, d, k);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL done_clear: got %h, want 0", d);
        end
    endtask

    task automatic test_read_path;
        logic [31:0] d;
        logic        k;
        int          hc;
        arp_rd_ip  = 32'h0A000001;
        arp_rd_mac = 48'hAABBCCDDEEFF;
        reg_write(3'd3, 32'd7);
        reg_write(3'd4, 32'd1);
        n_checks++;
        if (arp_rd_req !== 1'b1 || arp_wr_req !== 1'b0 || arp_rd_addr !== 5'd7) begin
            n_fail++;
            $display("FAIL rd_request: rdreq=%b wrreq=%b addr=%0d, want 1 0 7", arp_rd_req, arp_wr_req, arp_rd_addr);
        end
        run_table(2, 1'b1, hc);
        n_checks++;
        if (hc !== 2) begin
            n_fail++;
            $display("FAIL rd_req_cycles: got %0d, want 2", hc);
        end
        reg_read(3'd0, d, k);
        n_checks++;
        if (d !== 32'h0A000001) begin
            n_fail++;
            $display("FAIL rd_ip: got %h, want 0a000001", d);
        end
        reg_read(3'd1, d, k);
        n_checks++;
        if (d !== 32'h0000AABB) begin
            n_fail++;
            $display("FAIL rd_mac_hi: got %h, want 0000aabb", d);
        end
        reg_read(3'd2, d, k);
        n_checks++;
        if (d !== 32'hCCDDEEFF) begin
            n_fail++;
            $display("FAIL rd_mac_lo: got %h, want ccddeeff", d);
        end
        reg_read(3'd5, d, k);
        n_checks++;
        if (d !== 32'h8 || arp_wr_ip !== 32'h0A000001) begin
            n_fail++;
            $display("FAIL rd_status: status=%h wr_ip=%h, want 8 0a000001", d, arp_wr_ip);
        end
        reg_write(3'd5, 32'h8);
    endtask

    task automatic test_timeout;
        logic [31:0] d;
        logic        k;
        int          hc;
        reg_write(3'd4, 32'd1);
        run_table(0, 1'b1, hc);
        n_checks++;
        if (hc !== 4) begin
            n_fail++;
            $display("FAIL timeout_cycles: got %0d, want 4", hc);
        end
        reg_read(3'd5, d, k);
        n_checks++;
        if (d !== 32'h2) begin
            n_fail++;
            $display("FAIL timeout_status: got %h, want 2", d);
        end
        arp_rd_ip  = 32'h11111111;
        arp_rd_mac = 48'h222222222222;
        @(negedge clk);
        arp_rd_ack = 1'b1;
        @(negedge clk);
        arp_rd_ack = 1'b0;
        reg_read(3'd0, d, k);
        n_checks++;
        if (d !== 32'h0A000001) begin
            n_fail++;
            $display("FAIL stray_ack_ip: got %h, want 0a000001", d);
        end
        reg_read(3'd5, d, k);
        n_checks++;
        if (d !== 32'h2) begin
            n_fail++;
            $display("FAIL stray_ack_status: got %h, want 2", d);
        end
        reg_write(3'd5, 32'h2);
    endtask

    task automatic test_ack_at_timeout;
        logic [31:0] d;
        logic        k;
        int          hc;
        reg_write(3'd4, 32'd2);
        run_table(4, 1'b0, hc);
        n_checks++;
        if (hc !== 4) begin
            n_fail++;
            $display("FAIL ack_at_limit_cycles: got %0d, want 4", hc);
        end
        reg_read(3'd5, d, k);
        n_checks++;
        if (d !== 32'h8) begin
            n_fail++;
            $display("FAIL ack_at_limit_status: got %h, want 8", d);
        end
        reg_write(3'd5, 32'h8);
    endtask

    task automatic test_busy_protect;
        logic [31:0] d;
        logic        k;
        logic        saw_rd;
        logic        idle_seen;
        saw_rd    = 1'b0;
        idle_seen = 1'b0;
        reg_write(3'd4, 32'd2);
        saw_rd |= arp_rd_req;
        reg_write(3'd0, 32'hFFFFFFFF);
        saw_rd |= arp_rd_req;
        reg_write(3'd4, 32'd1);
        for (int i = 0; i < 20; i++) begin
            saw_rd |= arp_rd_req;
            if (!arp_wr_req) begin
                idle_seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (3) begin
            @(negedge clk);
            saw_rd |= arp_rd_req;
        end
        n_checks++;
        if (saw_rd !== 1'b0 || idle_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_cmd_ignored: rd_req_seen=%b wr_released=%b, want 0 1", saw_rd, idle_seen);
        end
        reg_read(3'd0, d, k);
        n_checks++;
        if (d !== 32'h0A000001) begin
            n_fail++;
            $display("FAIL busy_ip_kept: got %h, want 0a000001", d);
        end
        reg_read(3'd5, d, k);
        n_checks++;
        if (d !== 32'h6) begin
            n_fail++;
            $display("FAIL busy_status: got %h, want 6", d);
        end
        reg_write(3'd5, 32'h4);
        reg_read(3'd5, d, k);
        n_checks++;
        if (d !== 32'h2) begin
            n_fail++;
            $display("FAIL cmd_drop_clear: got %h, want 2", d);
        end
        reg_write(3'd5, 32'h2);
    endtask

    task automatic test_set_wins;
        logic [31:0] d;
        logic        k;
        reg_write(3'd4, 32'd2);
        reg_read(3'd5, d, k);
        n_checks++;
        if (d !== 32'h1) begin
            n_fail++;
            $display("FAIL busy_bit: got %h, want 1", d);
        end
        reg_req = 1'b1; reg_rd_wr_L = 1'b0; reg_addr = 3'd5; reg_wr_data = 32'h8;
        arp_wr_ack = 1'b1;
        @(negedge clk);
        reg_req = 1'b0; reg_wr_data = '0; arp_wr_ack = 1'b0;
        n_checks++;
        if (arp_wr_req !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_drops_req: got %b, want 0", arp_wr_req);
        end
        reg_read(3'd5, d, k);
        n_checks++;
        if (d !== 32'h8) begin
            n_fail++;
            $display("FAIL set_beats_clear: got %h, want 8", d);
        end
        reg_write(3'd5, 32'h8);
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        logic        k;
        reg_write(3'd0, 32'h12345678);
        reg_write(3'd2, 32'h9ABCDEF0);
        reg_write(3'd3, 32'd9);
        reg_write(3'd4, 32'd1);
        n_checks++;
        if (arp_rd_req !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_rd_req: got %b, want 1", arp_rd_req);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (arp_rd_req !== 1'b0 || arp_rd_addr !== 5'd0 || arp_wr_ip !== 32'h0 || arp_wr_mac !== 48'h0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: rdreq=%b addr=%0d ip=%h mac=%h, want all 0",
                     arp_rd_req, arp_rd_addr, arp_wr_ip, arp_wr_mac);
        end
        for (int a = 0; a < 6; a++) begin
            reg_read(3'(a), d, k);
            n_checks++;
            if (d !== 32'h0) begin
                n_fail++;
                $display("FAIL mid_reset_word%0d: got %h, want 0", a, d);
            end
        end
    endtask

    task automatic test_truncation;
        logic [31:0] d;
        logic        k;
        reg_write(3'd3, 32'h25);
        n_checks++;
        if (arp_rd_addr !== 5'd5 || arp_wr_addr !== 5'd5) begin
            n_fail++;
            $display("FAIL trunc_addr: rd=%0d wr=%0d, want 5 5", arp_rd_addr, arp_wr_addr);
        end
        reg_read(3'd3, d, k);
        n_checks++;
        if (d !== 32'd5) begin
            n_fail++;
            $display("FAIL trunc_index_read: got %h, want 5", d);
        end
        reg_write(3'd6, 32'hDEADBEEF);
        reg_read(3'd6, d, k);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL word6_read: got %h, want 0", d);
        end
        reg_write(3'd4, 32'd3);
        reg_read(3'd5, d, k);
        n_checks++;
        if (d !== 32'h0 || arp_rd_req !== 1'b0 || arp_wr_req !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_cmd_ignored: status=%h rdreq=%b wrreq=%b, want 0 0 0", d, arp_rd_req, arp_wr_req);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        reg_req     = 1'b0;
        reg_rd_wr_L = 1'b0;
        reg_addr    = '0;
        reg_wr_data = '0;
        arp_rd_mac  = '0;
        arp_rd_ip   = '0;
        arp_rd_ack  = 1'b0;
        arp_wr_ack  = 1'b0;
        test_reset();
        test_write_path();
        test_read_path();
        test_timeout();
        test_ack_at_timeout();
        test_busy_protect();
        test_set_wins();
        test_reset_mid();
        test_truncation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
